cmos_bus_arbiter: RTL and testbench

CMOS_BUS_ARBITER -- requirements
Module: cmos_bus_arbiter

---
 rtl/cmos_arb_pkg.sv | 26 ++
 rtl/rr_picker.sv | 30 +++
 rtl/cmos_bus_arbiter.sv | 113 +++++++++++
 tb/tb_cmos_bus_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/cmos_arb_pkg.sv
// Shared types and counter widths for the tristate bus arbiter.
// Counter widths cover the largest legal GUARD_CYC (15) and MAX_HOLD (255).
package cmos_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GUARD   = 2'd1,
    ST_DRIVE   = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  localparam int HOLD_W  = 8;
  localparam int GUARD_W = 4;
  localparam int MAX_REQ = 8;

  // Index of the set bit in a one-hot vector; zero for an all-zero vector.
  function automatic logic [2:0] onehot_idx(input logic [MAX_REQ-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set req bit searching upward
// from the requester after last_owner, wrapping around.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int OW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [OW-1:0]    last_owner,
  output logic [N_REQ-1:0] winner,
  output logic             valid
);

  always_comb begin
    logic [OW-1:0] pos;
    logic          found;
    winner = '0;
    found  = 1'b0;
    pos    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      pos = OW'((int'(last_owner) + i) % N_REQ);
      if (!found && req[pos]) begin
        winner[pos] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/cmos_bus_arbiter.sv
// Arbiter for one tristate wire shared by N_REQ CMOS drivers, with
// guard dead time around every drive window and a per-grant hold limit.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | no owner, all drivers off, waiting for any request
// ST_GUARD   | owner chosen, drivers still off for GUARD_CYC cycles
// ST_DRIVE   | owner's driver pair enabled, hold counter running
// ST_RELEASE | owner kept, drivers off for GUARD_CYC cycles, then IDLE
module cmos_bus_arbiter
  import cmos_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int GUARD_CYC = 1,
  parameter int MAX_HOLD  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] drv_en,
  output logic             busy,
  output logic             timeout
);

  localparam int OW = $clog2(N_REQ);
  localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD_CYC - 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(MAX_HOLD);

  arb_state_t         state;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [GUARD_W-1:0] guard_cnt;
  logic [OW-1:0]      last_owner;
  logic [N_REQ-1:0]   pick;
  logic               pick_valid;
  logic               owner_req;

  rr_picker #(.N_REQ(N_REQ), .OW(OW)) u_picker (
    .req        (req),
    .last_owner (last_owner),
    .winner     (pick),
    .valid      (pick_valid)
  );

  assign owner_req = |(req & gnt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      gnt        <= '0;
      drv_en     <= '0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
      hold_cnt   <= '0;
      guard_cnt  <= '0;
      last_owner <= OW'(N_REQ - 1);
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            gnt       <= pick;
            busy      <= 1'b1;
            guard_cnt <= GUARD_LOAD;
            state     <= ST_GUARD;
          end
        end
        ST_GUARD: begin
          // A withdrawn request skips the drive window entirely.
          if (!owner_req) begin
            guard_cnt <= GUARD_LOAD;
            state     <= ST_RELEASE;
          end else if (guard_cnt == '0) begin
            drv_en   <= gnt;
            hold_cnt <= HOLD_W'(1);
            state    <= ST_DRIVE;
          end else begin
            guard_cnt <= guard_cnt - 1'b1;
          end
        end
        ST_DRIVE: begin
          if (!owner_req || hold_cnt == HOLD_MAX) begin
            drv_en    <= '0;
            hold_cnt  <= '0;
            guard_cnt <= GUARD_LOAD;
            // Only a forced release while the owner still wants the bus.
            timeout   <= owner_req;
            state     <= ST_RELEASE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (guard_cnt == '0) begin
            last_owner <= OW'(onehot_idx(MAX_REQ'(gnt)));
            gnt        <= '0;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end else begin
            guard_cnt <= guard_cnt - 1'b1;
          end
        end
        default: begin
          gnt    <= '0;
          drv_en <= '0;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmos_bus_arbiter.sv
// Directed bench for cmos_bus_arbiter: instance a uses defaults,
// instance b uses MAX_HOLD=4 for the hold-limit scenarios.
module tb_cmos_bus_arbiter;
  import cmos_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_a = '0, req_b = '0;
  logic [3:0] gnt_a, drv_en_a, gnt_b, drv_en_b;
  logic       busy_a, timeout_a, busy_b, timeout_b;
  logic       mon_on = 1'b0;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  cmos_bus_arbiter dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .gnt(gnt_a),
    .drv_en(drv_en_a), .busy(busy_a), .timeout(timeout_a)
  );

  cmos_bus_arbiter #(.N_REQ(4), .GUARD_CYC(1), .MAX_HOLD(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .gnt(gnt_b),
    .drv_en(drv_en_b), .busy(busy_b), .timeout(timeout_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Structural invariants on both instances, sampled away from the edge.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("a_drv_onehot0", 32'($onehot0(drv_en_a)), 32'h1);
      chk("a_drv_subset",  32'(drv_en_a & ~gnt_a), 32'h0);
      chk("a_busy_state",  32'(busy_a), 32'(dut_a.state != ST_IDLE));
      chk("b_drv_onehot0", 32'($onehot0(drv_en_b)), 32'h1);
      chk("b_drv_subset",  32'(drv_en_b & ~gnt_b), 32'h0);
      chk("b_busy_state",  32'(busy_b), 32'(dut_b.state != ST_IDLE));
    end
  end

  initial begin
    logic [3:0] own_seq [5];
    logic [3:0] exp_g, exp_d;
    int g, p, tcount;

    own_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset
    rst_n = 1'b0;
    step();
    mon_on = 1'b1;
    step();
    chk("rst_gnt_a", 32'(gnt_a), 32'h0);
    chk("rst_drv_a", 32'(drv_en_a), 32'h0);
    chk("rst_busy_a", 32'(busy_a), 32'h0);
    chk("rst_to_a", 32'(timeout_a), 32'h0);
    chk("rst_gnt_b", 32'(gnt_b), 32'h0);
    rst_n = 1'b1;

    // Scenario 2 (b): all requesting, MAX_HOLD=4. Each grant spans 7 edges:
    // guard, 4 drive, release(timeout), idle -> 3 drivers-off cycles between owners.
    req_b  = 4'b1111;
    tcount = 0;
    for (int e = 1; e <= 30; e++) begin
      step();
      g = (e - 1) / 7;
      p = (e - 1) % 7;
      exp_g = (p == 6) ? 4'b0000 : own_seq[g];
      exp_d = (p >= 1 && p <= 4) ? own_seq[g] : 4'b0000;
      chk("s2_gnt", 32'(gnt_b), 32'(exp_g));
      chk("s2_drv", 32'(drv_en_b), 32'(exp_d));
      chk("s2_timeout", 32'(timeout_b), 32'(p == 5));
      if (timeout_b) tcount++;
    end
    chk("s2_timeout_count", 32'(tcount), 32'd4);
    req_b = 4'b0000;
    step();
    chk("s2_end_rel_drv", 32'(drv_en_b), 32'h0);
    chk("s2_end_rel_gnt", 32'(gnt_b), 32'b0001);
    chk("s2_end_rel_to", 32'(timeout_b), 32'h0);
    step();
    chk("s2_end_idle_gnt", 32'(gnt_b), 32'h0);
    chk("s2_end_idle_busy", 32'(busy_b), 32'h0);

    // Scenario 5 (b): owner drops exactly when hold counter reaches MAX_HOLD
    req_b = 4'b0100;
    step();
    chk("s5_gnt", 32'(gnt_b), 32'b0100);
    for (int e = 0; e < 4; e++) begin
      step();
      chk("s5_drv", 32'(drv_en_b), 32'b0100);
    end
    req_b = 4'b0000;
    step();
    chk("s5_rel_drv", 32'(drv_en_b), 32'h0);
    chk("s5_rel_gnt", 32'(gnt_b), 32'b0100);
    chk("s5_rel_timeout", 32'(timeout_b), 32'h0);
    chk("s5_rel_busy", 32'(busy_b), 32'h1);
    step();
    chk("s5_idle_gnt", 32'(gnt_b), 32'h0);

    // Scenario 1 (a): single requester, 5 drive cycles then drop
    req_a = 4'b0001;
    step();
    chk("s1_gnt", 32'(gnt_a), 32'b0001);
    chk("s1_guard_drv", 32'(drv_en_a), 32'h0);
    chk("s1_busy", 32'(busy_a), 32'h1);
    for (int e = 0; e < 5; e++) begin
      step();
      chk("s1_drv", 32'(drv_en_a), 32'b0001);
    end
    req_a = 4'b0000;
    step();
    chk("s1_rel_drv", 32'(drv_en_a), 32'h0);
    chk("s1_rel_gnt", 32'(gnt_a), 32'b0001);
    chk("s1_rel_to", 32'(timeout_a), 32'h0);
    step();
    chk("s1_idle_gnt", 32'(gnt_a), 32'h0);
    chk("s1_idle_busy", 32'(busy_a), 32'h0);

    // Scenario 3 (a): request withdrawn during guard
    req_a = 4'b0100;
    step();
    chk("s3_gnt", 32'(gnt_a), 32'b0100);
    req_a = 4'b0000;
    step();
    chk("s3_rel_drv", 32'(drv_en_a), 32'h0);
    chk("s3_rel_gnt", 32'(gnt_a), 32'b0100);
    chk("s3_rel_busy", 32'(busy_a), 32'h1);
    step();
    chk("s3_idle_gnt", 32'(gnt_a), 32'h0);
    chk("s3_idle_busy", 32'(busy_a), 32'h0);

    // Scenario 4 (a): last owner 2, so req 0010 wins; reset mid-drive
    req_a = 4'b0010;
    step();
    chk("s4_gnt", 32'(gnt_a), 32'b0010);
    step();
    chk("s4_drv", 32'(drv_en_a), 32'b0010);
    step();
    rst_n = 1'b0;
    step();
    chk("s4_rst_drv", 32'(drv_en_a), 32'h0);
    chk("s4_rst_gnt", 32'(gnt_a), 32'h0);
    chk("s4_rst_busy", 32'(busy_a), 32'h0);
    chk("s4_rst_to", 32'(timeout_a), 32'h0);
    rst_n = 1'b1;
    req_a = 4'b1010;
    step();
    chk("s4_after_rst_gnt", 32'(gnt_a), 32'b0010);
    step();
    chk("s4_after_rst_drv", 32'(drv_en_a), 32'b0010);
    req_a = 4'b0000;
    step();
    step();
    chk("s4_final_gnt", 32'(gnt_a), 32'h0);

    mon_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
